// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared definitions for the writeback arbiter and the issue stage:
//   NUM_FU / DATA_W / PREG_W / ROB_W  - machine-wide widths
//   FU_IDX_W                          - width of a functional-unit index
//   wb_entry_t                        - one buffered result {data, rd, rob_idx}
//   rob_age()                         - distance of a ROB index from the head
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

   localparam int NUM_FU   = 8;
   localparam int DATA_W   = 32;
   localparam int PREG_W   = 7;
   localparam int ROB_W    = 3;
   localparam int FU_IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [PREG_W-1:0] rd;
      logic [ROB_W-1:0]  rob_idx;
   } wb_entry_t;

   // Age of a ROB entry relative to the head; the subtraction wraps modulo
   // the ROB size, so the oldest in-flight entry has age 0.
   function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] rob_idx,
                                                input logic [ROB_W-1:0] head);
      return rob_idx - head;
   endfunction

endpackage

// File: rtl/wb_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin grant: the search starts at i_ptr and wraps modulo N; the first
// requesting index wins.
// Ports:
//   i_req         in  N      request vector
//   i_ptr         in  PTR_W  index where the search starts
//   o_grant       out N      one-hot grant (all zero when nothing requests)
//   o_grant_idx   out PTR_W  binary index of the granted requester
//   o_grant_valid out 1      some requester was granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int N     = 8,
   localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [N-1:0]     o_grant,
   output logic [PTR_W-1:0] o_grant_idx,
   output logic             o_grant_valid
);
   import wb_arbiter_pkg::*;

   // Wrap-around priority search starting at the pointer.
   always_comb begin
      int               v_pos;
      logic [PTR_W-1:0] v_sel;
      v_pos         = 0;
      v_sel         = '0;
      o_grant       = '0;
      o_grant_idx   = '0;
      o_grant_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         v_pos = int'(i_ptr) + k;
         v_pos = (v_pos >= N) ? (v_pos - N) : v_pos;
         v_sel = PTR_W'(v_pos);
         if (!o_grant_valid && i_req[v_sel]) begin
            o_grant_valid  = 1'b1;
            o_grant_idx    = v_sel;
            o_grant[v_sel] = 1'b1;
         end else begin
            o_grant_valid = o_grant_valid;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Serialises results from NUM_FU execution units onto the single writeback /
// completion bus. Each unit owns a one-entry buffer; a unit may present a new
// result whenever its buffer is empty or is being drained this cycle.
// Results whose ROB index is squashed by a mispredict are dropped, both when
// they sit in a buffer and when they arrive in the flush cycle.
//
// Build option: define WB_AGE_PRIO_EN to grant the oldest candidate (smallest
// (rob_idx - rob_head) mod ROB size) instead of round-robin; in that build
// there is no round-robin pointer. Without it rob_head is ignored.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   fu_valid/fu_data/fu_rd/fu_rob_idx   per-unit result offered
//   fu_ready                 per-unit back-pressure (issue stage EX_ready)
//   rob_head                 oldest ROB index (age-priority build only)
//   mispredict, flush_mask   squash request and ROB entries to squash
//   WB_valid/WB_data/WB_rd   register-file write and wakeup
//   CM_valid/CM_rob_idx      ROB completion
// Outputs are combinational from the buffers: a result accepted at edge t is
// visible during cycle t+1 if granted.
// -----------------------------------------------------------------------------
module wb_arbiter #(
   parameter int NUM_FU = wb_arbiter_pkg::NUM_FU,
   parameter int DATA_W = wb_arbiter_pkg::DATA_W,
   parameter int PREG_W = wb_arbiter_pkg::PREG_W,
   parameter int ROB_W  = wb_arbiter_pkg::ROB_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_FU-1:0]             fu_valid,
   input  logic [NUM_FU-1:0][DATA_W-1:0] fu_data,
   input  logic [NUM_FU-1:0][PREG_W-1:0] fu_rd,
   input  logic [NUM_FU-1:0][ROB_W-1:0]  fu_rob_idx,
   output logic [NUM_FU-1:0]             fu_ready,
   input  logic [ROB_W-1:0]              rob_head,
   input  logic                          mispredict,
   input  logic [(2**ROB_W)-1:0]         flush_mask,
   output logic                          WB_valid,
   output logic [DATA_W-1:0]             WB_data,
   output logic [PREG_W-1:0]             WB_rd,
   output logic                          CM_valid,
   output logic [ROB_W-1:0]              CM_rob_idx
);
   import wb_arbiter_pkg::*;

   localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   wb_entry_t [NUM_FU-1:0] r_buf;
   logic [NUM_FU-1:0]      r_buf_valid;

   logic [NUM_FU-1:0]      w_cand;        // buffered and not being squashed
   logic [NUM_FU-1:0]      w_in_flushed;  // incoming result is being squashed
   logic [NUM_FU-1:0]      w_grant;
   logic [IDX_W-1:0]       w_gidx;
   logic                   w_gvalid;

   // Candidate and squash qualification for every unit.
   always_comb begin
      w_cand       = '0;
      w_in_flushed = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         w_cand[i]       = r_buf_valid[i] && !(mispredict && flush_mask[r_buf[i].rob_idx]);
         w_in_flushed[i] = mispredict && flush_mask[fu_rob_idx[i]];
      end
   end

`ifdef WB_AGE_PRIO_EN
   logic [ROB_W-1:0] w_best_age;

   // Oldest-first grant; ROB indices are unique so the minimum is unique.
   always_comb begin
      w_grant    = '0;
      w_gidx     = '0;
      w_gvalid   = 1'b0;
      w_best_age = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (w_cand[i] && (!w_gvalid || (rob_age(r_buf[i].rob_idx, rob_head) < w_best_age))) begin
            w_gvalid   = 1'b1;
            w_gidx     = IDX_W'(i);
            w_best_age = rob_age(r_buf[i].rob_idx, rob_head);
         end else begin
            w_gvalid = w_gvalid;
         end
      end
      w_grant[w_gidx] = w_gvalid;
   end
`else
   logic [IDX_W-1:0] r_rr_ptr;
   logic             w_unused_rob_head;

   assign w_unused_rob_head = ^rob_head;

   rr_arbiter #(
      .N (NUM_FU)
   ) u_rr (
      .i_req         (w_cand),
      .i_ptr         (r_rr_ptr),
      .o_grant       (w_grant),
      .o_grant_idx   (w_gidx),
      .o_grant_valid (w_gvalid)
   );

   // Pointer moves just past the last winner; it holds when nothing is granted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rr_ptr <= '0;
      end else if (w_gvalid) begin
         r_rr_ptr <= (w_gidx == IDX_W'(NUM_FU - 1)) ? '0 : (w_gidx + IDX_W'(1));
      end else begin
         r_rr_ptr <= r_rr_ptr;
      end
   end
`endif

   // A slot can accept a result when empty or when it drains this cycle.
   always_comb begin
      fu_ready = ~r_buf_valid | w_grant;
   end

   // Per-unit buffer: squash first, then drain/reload or capture, else hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_buf_valid <= '0;
         r_buf       <= '0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (r_buf_valid[i] && !w_cand[i]) begin
               // buffered result belongs to a squashed instruction
               r_buf_valid[i] <= 1'b0;
               r_buf[i]       <= r_buf[i];
            end else if (w_grant[i] || !r_buf_valid[i]) begin
               // slot is free this cycle; squashed arrivals are not kept
               r_buf_valid[i] <= fu_valid[i] && !w_in_flushed[i];
               if (fu_valid[i] && !w_in_flushed[i]) begin
                  r_buf[i].data    <= fu_data[i];
                  r_buf[i].rd      <= fu_rd[i];
                  r_buf[i].rob_idx <= fu_rob_idx[i];
               end else begin
                  r_buf[i] <= r_buf[i];
               end
            end else begin
               r_buf_valid[i] <= r_buf_valid[i];
               r_buf[i]       <= r_buf[i];
            end
         end
      end
   end

   // Bus outputs from the granted buffer; all zero without a grant.
   always_comb begin
      CM_valid   = 1'b0;
      CM_rob_idx = '0;
      WB_valid   = 1'b0;
      WB_data    = '0;
      WB_rd      = '0;
      if (w_gvalid) begin
         CM_valid   = 1'b1;
         CM_rob_idx = r_buf[w_gidx].rob_idx;
         WB_valid   = (r_buf[w_gidx].rd != '0);
         WB_data    = r_buf[w_gidx].data;
         WB_rd      = r_buf[w_gidx].rd;
      end else begin
         CM_valid = 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed scenarios from the block's test plan plus a randomized run checked
// against a behavioural model of the per-unit buffers and the grant policy.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;
   localparam int NUM_FU = 8;
   localparam int DATA_W = 32;
   localparam int PREG_W = 7;
   localparam int ROB_W  = 3;
   localparam int ROBN   = 2**ROB_W;

   logic                          clk = 1'b0;
   logic                          rst;
   logic [NUM_FU-1:0]             fu_valid;
   logic [NUM_FU-1:0][DATA_W-1:0] fu_data;
   logic [NUM_FU-1:0][PREG_W-1:0] fu_rd;
   logic [NUM_FU-1:0][ROB_W-1:0]  fu_rob_idx;
   logic [NUM_FU-1:0]             fu_ready;
   logic [ROB_W-1:0]              rob_head;
   logic                          mispredict;
   logic [ROBN-1:0]               flush_mask;
   logic                          WB_valid;
   logic [DATA_W-1:0]             WB_data;
   logic [PREG_W-1:0]             WB_rd;
   logic                          CM_valid;
   logic [ROB_W-1:0]              CM_rob_idx;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit          m_valid [NUM_FU];
   logic [31:0] m_data  [NUM_FU];
   int          m_rd    [NUM_FU];
   int          m_rob   [NUM_FU];
   int          m_ptr;

   always #5 clk = ~clk;

   wb_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .fu_valid   (fu_valid),
      .fu_data    (fu_data),
      .fu_rd      (fu_rd),
      .fu_rob_idx (fu_rob_idx),
      .fu_ready   (fu_ready),
      .rob_head   (rob_head),
      .mispredict (mispredict),
      .flush_mask (flush_mask),
      .WB_valid   (WB_valid),
      .WB_data    (WB_data),
      .WB_rd      (WB_rd),
      .CM_valid   (CM_valid),
      .CM_rob_idx (CM_rob_idx)
   );

   task automatic drive_idle();
      fu_valid   = '0;
      fu_data    = '0;
      fu_rd      = '0;
      fu_rob_idx = '0;
      mispredict = 1'b0;
      flush_mask = '0;
   endtask

   task automatic present(input int u, input logic [31:0] d, input int rd, input int rob);
      fu_valid[u]   = 1'b1;
      fu_data[u]    = d;
      fu_rd[u]      = PREG_W'(rd);
      fu_rob_idx[u] = ROB_W'(rob);
   endtask

   // Leaves the bench just after a falling edge with reset released.
   task automatic apply_reset();
      @(negedge clk);
      drive_idle();
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0;
      fu_valid = 8'hA5;
      fu_rd    = '1;
      @(posedge clk);
      #1;
      checks++;
      if ({CM_valid, WB_valid, WB_rd, WB_data, CM_rob_idx} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got CM=%0b WB=%0b rd=%0h data=%0h rob=%0h required all 0",
                  CM_valid, WB_valid, WB_rd, WB_data, CM_rob_idx);
      end
      checks++;
      if (fu_ready !== 8'hFF) begin
         errors++;
         $display("FAIL reset_ready: got %0h required ff", fu_ready);
      end
      @(negedge clk);
      drive_idle();
      rst = 1'b1;
   endtask

   task automatic test_single();
      apply_reset();
      present(2, 32'hDEADBEEF, 5, 3);
      #1;
      checks++;
      if (fu_ready[2] !== 1'b1 || CM_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_accept: got ready2=%0b CM=%0b required 1 0", fu_ready[2], CM_valid);
      end
      @(negedge clk);
      drive_idle();
      #1;
      checks++;
      if ({CM_valid, WB_valid, WB_rd, WB_data, CM_rob_idx} !== {1'b1, 1'b1, 7'd5, 32'hDEADBEEF, 3'd3}) begin
         errors++;
         $display("FAIL single_wb: got CM=%0b WB=%0b rd=%0d data=%0h rob=%0d required 1 1 5 deadbeef 3",
                  CM_valid, WB_valid, WB_rd, WB_data, CM_rob_idx);
      end
      checks++;
      if (fu_ready[2] !== 1'b1) begin
         errors++;
         $display("FAIL single_ready: got %0b required 1", fu_ready[2]);
      end
      @(negedge clk);
      #1;
      checks++;
      if (CM_valid !== 1'b0 || WB_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_once: got CM=%0b WB=%0b required 0 0", CM_valid, WB_valid);
      end
   endtask

   task automatic test_rd_zero();
      @(negedge clk);
      present(1, 32'h0000_1234, 0, 4);
      @(negedge clk);
      drive_idle();
      #1;
      checks++;
      if (CM_valid !== 1'b1 || WB_valid !== 1'b0 || CM_rob_idx !== 3'd4) begin
         errors++;
         $display("FAIL rd_zero: got CM=%0b WB=%0b rob=%0d required 1 0 4", CM_valid, WB_valid, CM_rob_idx);
      end
   endtask

   task automatic test_contention();
      int exp_unit [3];
      int exp_rob  [3];
      logic [7:0] exp_rdy [3];
`ifdef WB_AGE_PRIO_EN
      exp_unit = '{7, 3, 0};
      exp_rob  = '{6, 7, 1};
      exp_rdy  = '{8'hF6, 8'hFE, 8'hFF};
`else
      exp_unit = '{0, 3, 7};
      exp_rob  = '{1, 7, 6};
      exp_rdy  = '{8'h77, 8'h7F, 8'hFF};
`endif
      apply_reset();
      rob_head = 3'd6;
      present(0, 32'h100, 10, 1);
      present(3, 32'h103, 13, 7);
      present(7, 32'h107, 17, 6);
      @(negedge clk);
      drive_idle();
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (CM_valid !== 1'b1 || CM_rob_idx !== ROB_W'(exp_rob[c]) ||
             WB_rd !== PREG_W'(10 + exp_unit[c]) || WB_data !== 32'(32'h100 + exp_unit[c])) begin
            errors++;
            $display("FAIL contention_grant%0d: got CM=%0b rob=%0d rd=%0d data=%0h required 1 %0d %0d %0h",
                     c, CM_valid, CM_rob_idx, WB_rd, WB_data, exp_rob[c], 10 + exp_unit[c], 32'h100 + exp_unit[c]);
         end
         checks++;
         if (fu_ready !== exp_rdy[c]) begin
            errors++;
            $display("FAIL contention_ready%0d: got %0h required %0h", c, fu_ready, exp_rdy[c]);
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if (CM_valid !== 1'b0) begin
         errors++;
         $display("FAIL contention_drained: got CM=%0b required 0", CM_valid);
      end
      rob_head = '0;
   endtask

   task automatic test_flush();
      apply_reset();
      rob_head = '0;
      present(1, 32'hAAAA_0002, 21, 2);
      present(4, 32'hBBBB_0005, 24, 5);
      @(negedge clk);
      drive_idle();
      mispredict = 1'b1;
      flush_mask = 8'b0010_0000;
      present(6, 32'hCCCC_0005, 26, 5);
      #1;
      checks++;
      if (CM_valid !== 1'b1 || CM_rob_idx !== 3'd2 || WB_rd !== 7'd21) begin
         errors++;
         $display("FAIL flush_survivor: got CM=%0b rob=%0d rd=%0d required 1 2 21", CM_valid, CM_rob_idx, WB_rd);
      end
      checks++;
      if (fu_ready[4] !== 1'b0 || fu_ready[6] !== 1'b1) begin
         errors++;
         $display("FAIL flush_ready: got r4=%0b r6=%0b required 0 1", fu_ready[4], fu_ready[6]);
      end
      @(negedge clk);
      drive_idle();
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (CM_valid !== 1'b0 || WB_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_dropped%0d: got CM=%0b rob=%0d required no completion", c, CM_valid, CM_rob_idx);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int u = 0; u < 4; u++) present(2 * u, 32'(32'h5000 + u), 30 + u, u);
      @(negedge clk);
      drive_idle();
      #1;
      checks++;
      if (CM_valid !== 1'b1 || fu_ready === 8'hFF) begin
         errors++;
         $display("FAIL midreset_loaded: got CM=%0b ready=%0h required 1 and some unit stalled", CM_valid, fu_ready);
      end
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if ({CM_valid, WB_valid, WB_rd, WB_data, CM_rob_idx} !== '0 || fu_ready !== 8'hFF) begin
         errors++;
         $display("FAIL midreset_async: got CM=%0b WB=%0b ready=%0h required 0 0 ff", CM_valid, WB_valid, fu_ready);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (CM_valid !== 1'b0 || WB_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release%0d: got CM=%0b WB=%0b required 0 0", c, CM_valid, WB_valid);
         end
         @(negedge clk);
      end
   endtask

   // Randomized traffic against the model. Each unit uses a fixed ROB index
   // (a permutation of 0..7) so buffered ROB indices are always unique.
   task automatic test_random();
      int          g;
      int          best;
      int          age;
      int          p;
      bit          cand;
      logic        e_cm, e_wb;
      logic [31:0] e_data;
      logic [6:0]  e_rd;
      logic [2:0]  e_rob;
      logic [7:0]  e_rdy;
      apply_reset();
      for (int i = 0; i < NUM_FU; i++) m_valid[i] = 1'b0;
      m_ptr = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         fu_valid   = NUM_FU'($urandom);
         mispredict = ($urandom_range(0, 5) == 0);
         flush_mask = ROBN'($urandom);
         rob_head   = ROB_W'($urandom);
         for (int i = 0; i < NUM_FU; i++) begin
            fu_data[i]    = $urandom;
            fu_rd[i]      = ($urandom_range(0, 3) == 0) ? 7'd0 : PREG_W'($urandom_range(1, 127));
            fu_rob_idx[i] = ROB_W'((i * 3 + 5) % ROBN);
         end
         #1;
         // choose the winner among live, unsquashed results
         g    = -1;
         best = ROBN;
         for (int k = 0; k < NUM_FU; k++) begin
`ifdef WB_AGE_PRIO_EN
            p   = k;
            age = (m_rob[p] - int'(rob_head) + ROBN) % ROBN;
`else
            p   = (m_ptr + k) % NUM_FU;
            age = k;
`endif
            cand = m_valid[p] && !(mispredict && flush_mask[m_rob[p]]);
            if (cand && age < best) begin
               best = age;
               g    = p;
            end
         end
         e_cm   = (g >= 0);
         e_wb   = (g >= 0) && (m_rd[g] != 0);
         e_data = (g >= 0) ? m_data[g] : 32'd0;
         e_rd   = (g >= 0) ? 7'(m_rd[g]) : 7'd0;
         e_rob  = (g >= 0) ? 3'(m_rob[g]) : 3'd0;
         for (int i = 0; i < NUM_FU; i++) e_rdy[i] = !m_valid[i] || (i == g);
         checks++;
         if (CM_valid !== e_cm || CM_rob_idx !== e_rob) begin
            errors++;
            $display("FAIL rand_cm cyc%0d: got %0b/%0d required %0b/%0d", cyc, CM_valid, CM_rob_idx, e_cm, e_rob);
         end
         checks++;
         if (WB_valid !== e_wb) begin
            errors++;
            $display("FAIL rand_wb_valid cyc%0d: got %0b required %0b", cyc, WB_valid, e_wb);
         end
         checks++;
         if (WB_data !== e_data || WB_rd !== e_rd) begin
            errors++;
            $display("FAIL rand_wb_data cyc%0d: got %0h/%0d required %0h/%0d", cyc, WB_data, WB_rd, e_data, e_rd);
         end
         checks++;
         if (fu_ready !== e_rdy) begin
            errors++;
            $display("FAIL rand_ready cyc%0d: got %0h required %0h", cyc, fu_ready, e_rdy);
         end
         // advance the model to the next edge
         for (int i = 0; i < NUM_FU; i++) begin
            if (m_valid[i] && mispredict && flush_mask[m_rob[i]]) begin
               m_valid[i] = 1'b0;
            end else if (!m_valid[i] || i == g) begin
               m_valid[i] = fu_valid[i] && !(mispredict && flush_mask[fu_rob_idx[i]]);
               if (m_valid[i]) begin
                  m_data[i] = fu_data[i];
                  m_rd[i]   = int'(fu_rd[i]);
                  m_rob[i]  = int'(fu_rob_idx[i]);
               end
            end
         end
         if (g >= 0) m_ptr = (g + 1) % NUM_FU;
         @(negedge clk);
      end
      drive_idle();
   endtask

   initial begin
      rst      = 1'b0;
      rob_head = '0;
      drive_idle();
      test_reset();
      test_single();
      test_rd_zero();
      test_contention();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Collects completed results from the execution units and serialises them onto the single writeback/completion bus. That bus feeds the register file write port and the issue-queue wakeup (WB_valid/WB_data/WB_rd), plus the ROB completion port. The block holds one result per functional unit and back-pressures each unit with a per-unit ready, which drives the issue stage's EX_ready vector. It also drops results belonging to squashed instructions on a misprediction.

## Interface
Parameters:
- NUM_FU, 8: number of functional units; index equals fu_sel
- DATA_W, 32: result width
- PREG_W, 7: physical register index width
- ROB_W, 3: ROB index width; 2**ROB_W equals the flush_mask width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- fu_valid  in  NUM_FU  unit i presents a result
- fu_data  in  NUM_FU x DATA_W  result data
- fu_rd  in  NUM_FU x PREG_W  destination physical register (0 = no register write)
- fu_rob_idx  in  NUM_FU x ROB_W  ROB index of the result
- fu_ready  out  NUM_FU  unit i may present a result this cycle (drives EX_ready)
- rob_head  in  ROB_W  oldest ROB index (used only with WB_AGE_PRIO_EN)
- mispredict  in  1  flush request
- flush_mask  in  2**ROB_W  ROB entries to squash
- WB_valid  out  1  register write/wakeup valid
- WB_data  out  DATA_W  write data
- WB_rd  out  PREG_W  write register
- CM_valid  out  1  completion to ROB
- CM_rob_idx  out  ROB_W  completing ROB index

## Operation
- Each unit has a one-entry buffer: buf_valid[i] plus {data, rd, rob_idx}.
- Capture: on fu_valid[i] && fu_ready[i], buffer i loads the result.
  - Exception: mispredict && flush_mask[fu_rob_idx[i]]. The result is discarded and buf_valid[i] is cleared.
- Ready: fu_ready[i] = !buf_valid[i] || grant[i]. This gives full throughput of one result per cycle per unit when granted every cycle.
- Candidates: cand[i] = buf_valid[i] && !(mispredict && flush_mask[buf_rob_idx[i]]).
- Grant: exactly one candidate per cycle, or none.
  - Default policy is round-robin. Search starts at rr_ptr, wrapping modulo NUM_FU.
  - After a grant to unit g, rr_ptr <= (g+1) mod NUM_FU. With no grant, rr_ptr holds.
- Outputs for granted unit g:
  - CM_valid = 1 and CM_rob_idx = buf_rob_idx[g].
  - WB_valid = CM_valid && buf_rd[g] != 0.
  - WB_data = buf_data[g] and WB_rd = buf_rd[g].
  - With no grant, all outputs are 0.
- Buffer update for unit i, applied in order:
  - Flushed entry (buffered rob_idx in flush_mask during mispredict) is cleared; no grant.
  - Otherwise a granted entry is cleared, or reloaded if a new fu_valid arrives in the same cycle.
  - Otherwise an empty entry captures fu_valid.
- Ungranted entries hold their contents unchanged.

## Timing
- Reset (rst low, asynchronous): all buf_valid = 0 and rr_ptr = 0.
  - Outputs during reset: WB_valid = CM_valid = 0, WB_data = 0, WB_rd = 0, CM_rob_idx = 0, fu_ready = all 1s.
- Reset deassertion mid-operation: all buffered results are lost. No output pulse occurs on release.
- Latency: a result accepted at edge t appears on WB/CM during cycle t+1 when granted, since outputs are combinational from the buffer.
- Mispredict while an entry is ungranted: the entry is cleared at that edge and never appears on WB.
- All NUM_FU buffers full: one drains per cycle. All ungranted units see fu_ready = 0 and hold their results.
- rr_ptr wrap: a grant to unit NUM_FU-1 sets rr_ptr to 0.

## Configuration
- WB_AGE_PRIO_EN, defined: the grant goes to the candidate with the smallest age.
  - age = (buf_rob_idx - rob_head) mod 2**ROB_W.
  - ROB indices are unique, so ties do not occur.
  - rr_ptr is not implemented.
- WB_AGE_PRIO_EN, undefined: round-robin as above. rob_head is ignored.

## Structure
- Shared package contains:
  - wb_entry_t packed struct {data, rd, rob_idx}
  - NUM_FU, PREG_W and ROB_W constants, shared with the issue stage
- Sub-module rr_arbiter: NUM_FU-wide request vector, pointer input, one-hot grant output, with wrap-around search.
- The age-priority path is inline logic under the macro.

## Test plan
- Single result: unit 2 presents rd=5, data=0xDEAD_BEEF, rob=3 at cycle 0 -> cycle 1: WB_valid=1, WB_rd=5, WB_data=0xDEADBEEF, CM_rob_idx=3; fu_ready[2] stays 1.
- rd=0 result: unit 1 presents a branch result with rd=0 -> CM_valid=1, WB_valid=0.
- Contention: units 0, 3 and 7 present results simultaneously with rr_ptr=0 -> grants in order 0, 3, 7 over cycles 1-3.
  - Units 3 and 7 hold their results while their fu_ready=0; no result is lost.
  - Age mode with rob_head=6 and robs {1, 7, 6} -> grant order is rob 6, 7, 1.
- Flush: buffers hold robs 2 and 5; mispredict with flush_mask=8'b0010_0000 -> rob 5 never appears; rob 2 completes.
  - An incoming result with rob 5 in the same cycle is also dropped.
- Reset mid-operation: 4 full buffers, rst asserted low -> outputs go to 0 immediately and fu_ready goes to all 1s.
  - After release, no WB pulse occurs.
